// File: rtl/fp_sqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_sqrt_pkg
// Description : Shared types and constants for the floating-point square-root
//               sequencer: FSM state encoding, operand class vector, format
//               biases, all-ones exponents, canonical qNaN and Inf patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_sqrt_pkg;

    localparam int c_root_w_default = 54;

    localparam logic [11:0] c_bias_dbl     = 12'd1023;
    localparam logic [11:0] c_bias_sgl     = 12'd127;
    localparam logic [10:0] c_exp_ones_dbl = 11'h7FF;
    localparam logic [10:0] c_exp_ones_sgl = 11'h0FF;

    localparam logic [63:0] c_qnan_dbl = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] c_qnan_sgl = 64'h0000_0000_7FC0_0000;
    localparam logic [63:0] c_inf_dbl  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] c_inf_sgl  = 64'h0000_0000_7F80_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        PACK = 3'd3,
        OUT  = 3'd4
    } state_t;

    // One-hot operand class; exactly one bit is set for any operand.
    typedef struct packed {
        logic nan;
        logic zero;
        logic denorm;
        logic neg;
        logic inf;
        logic normal;
    } fp_class_t;

endpackage
`default_nettype wire

// File: rtl/fp_sqrt_classify.sv
`default_nettype none
// ============================================================================
// Module      : fp_sqrt_classify
// Description : Combinational operand splitter/classifier. Extracts sign and
//               a 52-bit left-aligned fraction, produces the one-hot class
//               (nan/zero/denorm/neg/inf/normal, first match wins), the odd
//               flag (biased exponent even => unbiased exponent odd) and the
//               halved result exponent (exp + bias) >> 1.
// Ports       : i_is_float  1 = single in [31:0], 0 = double
//               i_operand   raw 64-bit operand
//               o_sign, o_frac[51:0], o_cls, o_odd, o_res_exp[11:0]
// Revision    : 1.0 - initial release
// ============================================================================
module fp_sqrt_classify
    import fp_sqrt_pkg::*;
(
    input  logic        i_is_float,
    input  logic [63:0] i_operand,
    output logic        o_sign,
    output logic [51:0] o_frac,
    output fp_class_t   o_cls,
    output logic        o_odd,
    output logic [11:0] o_res_exp
);

    logic [10:0] w_exp;
    logic [10:0] w_exp_ones;
    logic [11:0] w_bias;
    logic [11:0] w_exp_sum;
    logic        w_exp_max;
    logic        w_exp_zero;
    logic        w_frac_zero;

    always_comb begin
        if (i_is_float) begin
            o_sign     = i_operand[31];
            w_exp      = {3'b000, i_operand[30:23]};
            o_frac     = {i_operand[22:0], 29'b0};
            w_exp_ones = c_exp_ones_sgl;
            w_bias     = c_bias_sgl;
        end else begin
            o_sign     = i_operand[63];
            w_exp      = i_operand[62:52];
            o_frac     = i_operand[51:0];
            w_exp_ones = c_exp_ones_dbl;
            w_bias     = c_bias_dbl;
        end

        w_exp_max   = (w_exp == w_exp_ones);
        w_exp_zero  = (w_exp == 11'd0);
        w_frac_zero = (o_frac == 52'd0);

        o_cls = '0;
        if (w_exp_max && !w_frac_zero) begin
            o_cls.nan = 1'b1;
        end else if (w_exp_zero && w_frac_zero) begin
            o_cls.zero = 1'b1;
        end else if (w_exp_zero) begin
            o_cls.denorm = 1'b1;
        end else if (o_sign) begin
            o_cls.neg = 1'b1;
        end else if (w_exp_max) begin
            o_cls.inf = 1'b1;
        end else begin
            o_cls.normal = 1'b1;
        end

        // Both biases are odd, so an even biased exponent means an odd
        // unbiased one; the radicand is then pre-doubled.
        o_odd     = ~w_exp[0];
        w_exp_sum = {1'b0, w_exp} + w_bias;
        o_res_exp = w_exp_sum >> 1;
    end

endmodule
`default_nettype wire

// File: rtl/fp_sqrt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fp_sqrt_sequencer
// Description : Sequences one IEEE single/double square root. Accepts an
//               operand, resolves special values locally, otherwise drives an
//               external mantissa-root core (start/done with watchdog) and
//               packs the result.
// Ports       : clk, rstN (async active-low)
//               inValid/inReady/isFloat/in[63:0]      operand request
//               coreStart/coreRadicand/coreDone/coreRoot  root core
//               outValid/outReady/out[63:0]/flagInvalid/flagTimeout result
// Options     : FP_SQRT_ROUND_NEAREST_EN - round to nearest with the guard
//               bit; otherwise the mantissa is truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_sqrt_sequencer
    import fp_sqrt_pkg::*;
#(
    parameter int ROOT_W         = c_root_w_default,
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic                  isFloat,
    input  logic [63:0]           in,
    output logic                  coreStart,
    output logic [2*ROOT_W-1:0]   coreRadicand,
    input  logic                  coreDone,
    input  logic [ROOT_W-1:0]     coreRoot,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [63:0]           out,
    output logic                  flagInvalid,
    output logic                  flagTimeout
);

    localparam int              WD_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT_CYCLES - 1);

    state_t                state_q,     state_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  core_start_q, core_start_d;
    logic [2*ROOT_W-1:0]   radicand_q,  radicand_d;
    logic                  out_valid_q, out_valid_d;
    logic [63:0]           out_q,       out_d;
    logic                  flag_inv_q,  flag_inv_d;
    logic                  flag_to_q,   flag_to_d;
    logic [WD_W-1:0]       wd_q,        wd_d;
    logic                  is_float_q,  is_float_d;
    logic                  sign_q,      sign_d;
    fp_class_t             cls_q,       cls_d;
    logic [11:0]           res_exp_q,   res_exp_d;
    logic [ROOT_W-1:0]     root_q,      root_d;

    logic                  w_sign;
    logic [51:0]           w_frac;
    fp_class_t             w_cls;
    logic                  w_odd;
    logic [11:0]           w_res_exp;
    logic [2*ROOT_W-1:0]   w_radicand;
    logic [63:0]           w_qnan;
    logic                  w_rnd_dbl;
    logic                  w_rnd_sgl;
    logic [62:0]           w_pack_dbl;
    logic [30:0]           w_pack_sgl;
    logic                  w_unused;

    // Classification runs on the live input so the class, radicand and
    // start pulse are all registered at accept and valid throughout LOAD.
    fp_sqrt_classify u_classify (
        .i_is_float (isFloat),
        .i_operand  (in),
        .o_sign     (w_sign),
        .o_frac     (w_frac),
        .o_cls      (w_cls),
        .o_odd      (w_odd),
        .o_res_exp  (w_res_exp)
    );

    // Radicand carries 2 integer bits: 2*1.f for odd exponents, 1.f otherwise.
    assign w_radicand = w_odd ? {1'b1,  w_frac, {(2*ROOT_W-53){1'b0}}}
                              : {2'b01, w_frac, {(2*ROOT_W-54){1'b0}}};

    assign w_qnan = is_float_q ? c_qnan_sgl : c_qnan_dbl;

`ifdef FP_SQRT_ROUND_NEAREST_EN
    assign w_rnd_dbl = root_q[0];
    assign w_rnd_sgl = root_q[29];
`else
    assign w_rnd_dbl = 1'b0;
    assign w_rnd_sgl = 1'b0;
`endif

    // Exponent and mantissa are added as one field so a mantissa carry-out
    // clears the mantissa and bumps the exponent in a single step.
    assign w_pack_dbl = {res_exp_q[10:0], root_q[52:1]}  + {62'd0, w_rnd_dbl};
    assign w_pack_sgl = {res_exp_q[7:0],  root_q[52:30]} + {30'd0, w_rnd_sgl};

    // The root integer bit is always 1 and resExp never exceeds 11 bits.
    assign w_unused = ^{res_exp_q[11], root_q[ROOT_W-1:53], root_q[0], root_q[29]};

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        core_start_d = 1'b0;
        radicand_d   = radicand_q;
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        flag_inv_d   = flag_inv_q;
        flag_to_d    = flag_to_q;
        wd_d         = wd_q;
        is_float_d   = is_float_q;
        sign_d       = sign_q;
        cls_d        = cls_q;
        res_exp_d    = res_exp_q;
        root_d       = root_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (inValid && in_ready_q) begin
                    is_float_d   = isFloat;
                    sign_d       = w_sign;
                    cls_d        = w_cls;
                    res_exp_d    = w_res_exp;
                    in_ready_d   = 1'b0;
                    core_start_d = w_cls.normal;
                    if (w_cls.normal) begin
                        radicand_d = w_radicand;
                    end
                    state_d = LOAD;
                end
            end
            LOAD: begin
                wd_d = '0;
                if (cls_q.normal) begin
                    state_d = WAIT;
                end else begin
                    if (cls_q.nan || cls_q.neg) begin
                        out_d      = w_qnan;
                        flag_inv_d = 1'b1;
                    end else if (cls_q.zero || cls_q.denorm) begin
                        out_d = is_float_q ? {32'd0, sign_q, 31'd0} : {sign_q, 63'd0};
                    end else begin
                        out_d = is_float_q ? c_inf_sgl : c_inf_dbl;
                    end
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            WAIT: begin
                if (coreDone) begin
                    root_d  = coreRoot;
                    state_d = PACK;
                end else if (wd_q == c_wd_last) begin
                    out_d       = w_qnan;
                    flag_to_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            PACK: begin
                out_d       = is_float_q ? {32'd0, 1'b0, w_pack_sgl} : {1'b0, w_pack_dbl};
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (outReady) begin
                    out_valid_d = 1'b0;
                    out_d       = '0;
                    flag_inv_d  = 1'b0;
                    flag_to_d   = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                in_ready_d = 1'b1;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            core_start_q <= 1'b0;
            radicand_q   <= '0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            flag_inv_q   <= 1'b0;
            flag_to_q    <= 1'b0;
            wd_q         <= '0;
            is_float_q   <= 1'b0;
            sign_q       <= 1'b0;
            cls_q        <= '0;
            res_exp_q    <= '0;
            root_q       <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            core_start_q <= core_start_d;
            radicand_q   <= radicand_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            flag_inv_q   <= flag_inv_d;
            flag_to_q    <= flag_to_d;
            wd_q         <= wd_d;
            is_float_q   <= is_float_d;
            sign_q       <= sign_d;
            cls_q        <= cls_d;
            res_exp_q    <= res_exp_d;
            root_q       <= root_d;
        end
    end

    assign inReady      = in_ready_q;
    assign coreStart    = core_start_q;
    assign coreRadicand = radicand_q;
    assign outValid     = out_valid_q;
    assign out          = out_q;
    assign flagInvalid  = flag_inv_q;
    assign flagTimeout  = flag_to_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_sqrt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_sqrt_sequencer
// Description : Scoreboard bench for fp_sqrt_sequencer. A reference model
//               computes IEEE square roots from the operand with integer
//               arithmetic; a behavioural root core answers coreStart with
//               isqrt(coreRadicand) after a programmable delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_sqrt_sequencer;

    localparam int ROOT_W         = 54;
    localparam int TIMEOUT_CYCLES = 128;
    localparam int RAD_W          = 2 * ROOT_W;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic              inValid = 1'b0;
    logic              inReady;
    logic              isFloat = 1'b0;
    logic [63:0]       op_in = '0;
    logic              coreStart;
    logic [RAD_W-1:0]  coreRadicand;
    logic              coreDone = 1'b0;
    logic [ROOT_W-1:0] coreRoot = '0;
    logic              outValid;
    logic              outReady = 1'b0;
    logic [63:0]       res_out;
    logic              flagInvalid;
    logic              flagTimeout;

    int          checks = 0;
    int          errors = 0;
    int          starts = 0;
    int          force_delay = -1;
    bit          rdy_rand = 1'b1;
    bit          rdy_low = 1'b0;
    logic [65:0] sb[$];
    logic [65:0] mon_exp;

    fp_sqrt_sequencer #(.ROOT_W(ROOT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
        .isFloat(isFloat), .in(op_in), .coreStart(coreStart),
        .coreRadicand(coreRadicand), .coreDone(coreDone), .coreRoot(coreRoot),
        .outValid(outValid), .outReady(outReady), .out(res_out),
        .flagInvalid(flagInvalid), .flagTimeout(flagTimeout)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] isqrt(input logic [127:0] x);
        logic [127:0] rem, r, b;
        rem = x; r = '0; b = 128'd1 << 126;
        while (b > rem && b != 0) b = b >> 2;
        while (b != 0) begin
            if (rem >= r + b) begin
                rem = rem - (r + b);
                r   = (r >> 1) + b;
            end else begin
                r = r >> 1;
            end
            b = b >> 2;
        end
        return r[63:0];
    endfunction

    // Reference result {flagInvalid, flagTimeout, out} straight from IEEE rules.
    function automatic logic [65:0] ref_sqrt(input logic f, input logic [63:0] v);
        logic s; int e, emax, bias, fb, unb, re;
        logic [127:0] frac, mi, r;
        logic [63:0] qnan, inf, res;
        if (f) begin
            s = v[31]; e = int'(v[30:23]); frac = 128'(v[22:0]);
            fb = 23; bias = 127; emax = 255; qnan = 64'h7FC0_0000; inf = 64'h7F80_0000;
        end else begin
            s = v[63]; e = int'(v[62:52]); frac = 128'(v[51:0]);
            fb = 52; bias = 1023; emax = 2047;
            qnan = 64'h7FF8_0000_0000_0000; inf = 64'h7FF0_0000_0000_0000;
        end
        if (e == emax && frac != 0) return {2'b10, qnan};
        if (e == 0) return {2'b00, (f ? {32'd0, s, 31'd0} : {s, 63'd0})};
        if (s) return {2'b10, qnan};
        if (e == emax) return {2'b00, inf};
        unb = e - bias;
        mi  = (128'd1 << fb) | frac;
        if (unb % 2 != 0) begin
            mi  = mi << 1;
            unb = unb - 1;
        end
`ifdef FP_SQRT_ROUND_NEAREST_EN
        r = 128'(isqrt(mi << (fb + 2)));
        r = (r + 1) >> 1;
`else
        r = 128'(isqrt(mi << fb));
`endif
        re = unb / 2 + bias;
        if (r >= (128'd1 << (fb + 1))) begin
            r  = r >> 1;
            re = re + 1;
        end
        if (f) res = {32'd0, 1'b0, re[7:0], r[22:0]};
        else   res = {1'b0, re[10:0], r[51:0]};
        return {2'b00, res};
    endfunction

    function automatic logic [63:0] rand_op(input logic f);
        int k; logic s; logic [10:0] e; logic [51:0] fr;
        k = $urandom_range(0, 9); s = 1'($urandom_range(0, 1));
        fr = {$urandom, $urandom};
        case (k)
            0: begin e = f ? 11'hFF : 11'h7FF; fr[0] = 1'b1; end
            1: begin e = 0; fr = '0; end
            2: begin e = 0; fr[0] = 1'b1; end
            3: begin e = f ? 11'hFF : 11'h7FF; fr = '0; end
            default: begin
                e = f ? 11'($urandom_range(1, 254)) : 11'($urandom_range(1, 2046));
                s = (k == 4);
            end
        endcase
        return f ? {32'd0, s, e[7:0], fr[22:0]} : {s, e, fr};
    endfunction

    // Presents one operand; returns #1 after the accepting edge (LOAD cycle).
    task automatic send(input logic f, input logic [63:0] v, input logic [65:0] exp);
        int n;
        n = 0;
        while (!inReady) begin
            @(posedge clk); #1;
            n++;
            if (n > 3000) begin
                chk("send_wait_inReady", 0, 1);
                return;
            end
        end
        sb.push_back(exp);
        inValid = 1'b1; isFloat = f; op_in = v;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || outValid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(sb.size()), 0);
    endtask

    // outReady driver
    initial forever begin
        @(posedge clk); #1;
        if (rdy_low)       outReady = 1'b0;
        else if (rdy_rand) outReady = ($urandom_range(0, 3) != 0);
        else               outReady = 1'b1;
    end

    // Behavioural root core
    initial begin
        logic [RAD_W-1:0] rad;
        logic [63:0]      rt;
        int               d;
        forever begin
            @(negedge clk);
            if (coreStart) begin
                rad = coreRadicand;
                starts++;
                d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 6));
                @(posedge clk); #1;
                repeat (d) begin @(posedge clk); #1; end
                rt = isqrt(128'(rad));
                coreRoot = rt[ROOT_W-1:0];
                coreDone = 1'b1;
                @(posedge clk); #1;
                coreDone = 1'b0;
                if (d < TIMEOUT_CYCLES && rstN) begin
                    chk("norm_lat_pack", 32'(outValid), 0);
                    @(posedge clk); #1;
                    chk("norm_lat_out", 32'(outValid), 1);
                end
            end
        end
    end

    // Scoreboard monitor
    initial forever begin
        @(negedge clk);
        if (rstN && outValid && outReady) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got %h, required no output", res_out);
            end else begin
                mon_exp = sb.pop_front();
                chk("result", {62'd0, flagInvalid, flagTimeout, res_out}, 128'(mon_exp));
            end
        end
    end

    logic [63:0] sp_in  [5] = '{64'hBFF0_0000_0000_0000, 64'h0, 64'h8000_0000_0000_0000,
                                64'h7FF0_0000_0000_0000, 64'h1};
    logic [65:0] sp_exp [5] = '{{2'b10, 64'h7FF8_0000_0000_0000}, {2'b00, 64'h0},
                                {2'b00, 64'h8000_0000_0000_0000},
                                {2'b00, 64'h7FF0_0000_0000_0000}, {2'b00, 64'h0}};

    initial begin
        int s0, hi;
        logic [63:0] held, v;
        logic f;

        repeat (3) @(posedge clk); #1;
        chk("rst_inReady", 32'(inReady), 1);
        chk("rst_coreStart", 32'(coreStart), 0);
        chk("rst_outValid", 32'(outValid), 0);
        chk("rst_out", 128'(res_out), 0);
        chk("rst_flags", {flagInvalid, flagTimeout}, 0);
        chk("rst_radicand", 128'(coreRadicand), 0);
        rstN = 1'b1;
        @(posedge clk); #1;

        send(1'b0, 64'h4010_0000_0000_0000, {2'b00, 64'h4000_0000_0000_0000});
        chk("start_dbl4", 32'(coreStart), 1);
        chk("rad_msb_dbl4", 32'(coreRadicand[RAD_W-1 -: 2]), 2'b01);
        send(1'b1, 64'h4110_0000, {2'b00, 64'h4040_0000});
        chk("rad_msb_sgl9", 32'(coreRadicand[RAD_W-1]), 1);
        drain();

        s0 = starts;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, sp_in[i], sp_exp[i]);
            chk("spec_lat1", 32'(outValid), 0);
            @(posedge clk); #1;
            chk("spec_lat2", 32'(outValid), 1);
        end
        drain();
        chk("no_core_for_specials", 32'(starts - s0), 0);

        // Watchdog: core silent, then a late done while idle
        rdy_rand = 1'b0;
        force_delay = 140;
        send(1'b0, 64'h4010_0000_0000_0000, {2'b01, 64'h7FF8_0000_0000_0000});
        drain();
        hi = 0;
        repeat (150) begin @(posedge clk); #1; if (outValid) hi++; end
        chk("late_done_ignored", 32'(hi), 0);

        // Done in the very cycle the watchdog expires wins; one cycle later loses
        force_delay = TIMEOUT_CYCLES - 1;
        send(1'b1, 64'h4110_0000, {2'b00, 64'h4040_0000});
        drain();
        force_delay = TIMEOUT_CYCLES;
        send(1'b1, 64'h4110_0000, {2'b01, 64'h7FC0_0000});
        drain();
        repeat (5) @(posedge clk); #1;
        force_delay = -1;

        // Output stall with a competing request while busy
        rdy_low = 1'b1;
        send(1'b1, 64'h7F80_0000, {2'b00, 64'h7F80_0000});
        @(posedge clk); #1;
        held = res_out;
        chk("stall_valid_up", 32'(outValid), 1);
        inValid = 1'b1; isFloat = 1'b0; op_in = 64'h4010_0000_0000_0000;
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(outValid), 1);
            chk("stall_out", 128'(res_out), 128'(held));
            chk("stall_inReady", 32'(inReady), 0);
        end
        inValid = 1'b0;
        rdy_low = 1'b0;
        drain();

        // Reset while waiting on the core
        force_delay = 140;
        send(1'b0, 64'h4010_0000_0000_0000, {2'b00, 64'h4000_0000_0000_0000});
        repeat (5) @(posedge clk);
        #3 rstN = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_inReady", 32'(inReady), 1);
        chk("mid_rst_outValid", 32'(outValid), 0);
        chk("mid_rst_out", {flagInvalid, flagTimeout, res_out}, 0);
        chk("mid_rst_core", {coreStart, coreRadicand}, 0);
        repeat (2) @(posedge clk);
        #3 rstN = 1'b1;
        s0 = starts;
        repeat (150) @(posedge clk); #1;
        chk("no_start_after_rst", 32'(starts - s0), 0);
        force_delay = -1;
        send(1'b0, 64'h4010_0000_0000_0000, {2'b00, 64'h4000_0000_0000_0000});
        drain();

        // Randomized traffic
        rdy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            f = 1'($urandom_range(0, 1));
            v = rand_op(f);
            send(f, v, ref_sqrt(f, v));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
